// File: rtl/fpga_pkg.sv
// Definitions shared by the core and the program in/out channel blocks.
// Word width default, channel word type and channel completion states.
package fpga_pkg;

  localparam int MemoryElementWidthDefault = 12;

  typedef logic [MemoryElementWidthDefault-1:0] word_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/out_channel_reader_if.sv
// Core push side and host stream side of the program out channel.
// The reader uses the slave view; the core/host side uses master.
interface out_channel_reader_if
  import fpga_pkg::*;
#(
  parameter int W          = MemoryElementWidthDefault,
  parameter int NOut       = 8,
  parameter int NDropWidth = 8
);
  localparam int CW = $clog2(NOut + 1);

  logic                  outWrite;
  logic [W-1:0]          outData;
  logic                  outReady;
  logic                  finished;
  logic                  hostValid;
  logic [W-1:0]          hostData;
  logic                  hostReady;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic [NDropWidth-1:0] dropped;
  logic                  drained;

  modport master (
    output outWrite, outData, finished, hostReady,
    input  outReady, hostValid, hostData,
    input  count, overflow, dropped, drained
  );

  modport slave (
    input  outWrite, outData, finished, hostReady,
    output outReady, hostValid, hostData,
    output count, overflow, dropped, drained
  );

endinterface

// File: rtl/out_channel_ring.sv
// Ring storage with wrap-at-NOut pointers and an occupancy count.
// next_head is the word that sits at the read pointer after this edge.
module out_channel_ring #(
  parameter int W    = 12,
  parameter int NOut = 8,
  parameter int CW   = $clog2(NOut + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          full,
  output logic          empty,
  output logic [W-1:0]  next_head
);
  localparam int PW = $clog2(NOut);
  localparam logic [PW-1:0] LAST  = PW'(NOut - 1);
  localparam logic [CW-1:0] DEPTH = CW'(NOut);

  logic [W-1:0]  mem [NOut];
  logic [PW-1:0] rd, wr, rd_nxt, wr_nxt;

  always_comb begin
    rd_nxt = rd;
    if (pop)
      rd_nxt = (rd == LAST) ? '0 : rd + PW'(1);
  end

  always_comb begin
    wr_nxt = wr;
    if (push)
      wr_nxt = (wr == LAST) ? '0 : wr + PW'(1);
  end

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd_nxt;
      wr    <= wr_nxt;
      count <= count_nxt;
    end
  end

  // Contents survive reset; only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr] <= wdata;
  end

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign next_head = mem[rd_nxt];

endmodule

// File: rtl/out_channel_reader.sv
// Reader end of the program out channel: buffers core words and
// streams them to the host, tracking overflow and channel drain.
module out_channel_reader
  import fpga_pkg::*;
#(
  parameter int MemoryElementWidth = MemoryElementWidthDefault,
  parameter int NOut               = 8,
  parameter int NDropWidth         = 8
) (
  input logic                 clock,
  input logic                 reset,
  out_channel_reader_if.slave bus
);
  localparam int CW = $clog2(NOut + 1);
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_FLUSH = FLUSH;
  localparam logic [1:0] S_DONE  = DONE;

  logic [CW-1:0] count, count_nxt;
  logic          full, empty;
  logic          rd_fire, wr_ok, wr_rej, more;
  logic [1:0]    state, state_nxt;
  logic [MemoryElementWidth-1:0] next_head;

  assign rd_fire = bus.hostValid & bus.hostReady;
  assign wr_ok   = bus.outWrite & (~full | rd_fire);
  assign wr_rej  = bus.outWrite & ~wr_ok;
  // Only words stored before this edge may load the head.
  assign more    = rd_fire ? (count > CW'(1)) : ~empty;

  out_channel_ring #(
    .W    (MemoryElementWidth),
    .NOut (NOut),
    .CW   (CW)
  ) u_ring (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_ok),
    .pop       (rd_fire),
    .wdata     (bus.outData),
    .count     (count),
    .count_nxt (count_nxt),
    .full      (full),
    .empty     (empty),
    .next_head (next_head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.hostValid <= 1'b0;
      bus.hostData  <= '0;
      bus.outReady  <= 1'b1;
    end else begin
      bus.hostValid <= more;
      if (more)
        bus.hostData <= next_head;
      bus.outReady  <= (count_nxt != CW'(NOut));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.overflow <= 1'b0;
      bus.dropped  <= '0;
    end else if (wr_rej) begin
      bus.overflow <= 1'b1;
      if (~&bus.dropped)
        bus.dropped <= bus.dropped + NDropWidth'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN:
        if (bus.finished) state_nxt = S_FLUSH;
      S_FLUSH:
        if (!bus.finished) state_nxt = S_RUN;
        else if (empty && !bus.outWrite) state_nxt = S_DONE;
      S_DONE:
        if (!bus.finished) state_nxt = S_RUN;
        else if (bus.outWrite) state_nxt = S_FLUSH;
      default:
        state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_RUN;
    else        state <= state_nxt;
  end

  assign bus.count   = count;
  assign bus.drained = (state == S_DONE);

endmodule

// File: tb/tb_out_channel_reader.sv
// Bench for out_channel_reader: queue-based reference model checked
// every cycle, plus directed literal checks; second instance has NOut=3.
module tb_out_channel_reader;

  localparam int N  = 8;
  localparam int M_RUN = 0, M_FLUSH = 1, M_DONE = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  out_channel_reader_if #(.W(12), .NOut(N), .NDropWidth(8)) ifa ();
  out_channel_reader_if #(.W(12), .NOut(3), .NDropWidth(8)) ifb ();

  out_channel_reader #(
    .MemoryElementWidth(12), .NOut(N), .NDropWidth(8)
  ) dut_a (.clock(clock), .reset(reset), .bus(ifa));

  out_channel_reader #(
    .MemoryElementWidth(12), .NOut(3), .NDropWidth(8)
  ) dut_b (.clock(clock), .reset(reset), .bus(ifb));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: held words in order, whether the oldest one
  // is already shown to the host, completion state, drop accounting.
  logic [11:0] mq[$];
  logic [11:0] rxa[$];
  logic [11:0] rxb[$];
  bit mv = 0;
  int mst = M_RUN;
  bit movf = 0;
  int mdrop = 0;
  bit m_rd, m_acc;
  int m_held, m_old;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mv = 0;
      mst = M_RUN;
      movf = 0;
      mdrop = 0;
    end else begin
      m_rd   = mv && ifa.hostReady;
      m_held = mq.size();
      m_acc  = ifa.outWrite && (m_held < N || m_rd);
      case (mst)
        M_RUN:   if (ifa.finished) mst = M_FLUSH;
        M_FLUSH: if (!ifa.finished) mst = M_RUN;
                 else if (m_held == 0 && !ifa.outWrite) mst = M_DONE;
        default: if (!ifa.finished) mst = M_RUN;
                 else if (ifa.outWrite) mst = M_FLUSH;
      endcase
      if (m_rd) rxa.push_back(mq.pop_front());
      m_old = mq.size();
      if (m_acc) mq.push_back(ifa.outData);
      mv = (m_old > 0);
      if (ifa.outWrite && !m_acc) begin
        movf = 1;
        if (mdrop < 255) mdrop++;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("a_valid", ifa.hostValid, mv);
      if (mv) chk("a_data", ifa.hostData, mq[0]);
      chk("a_count", ifa.count, mq.size());
      chk("a_outready", ifa.outReady, mq.size() < N);
      chk("a_overflow", ifa.overflow, movf);
      chk("a_dropped", ifa.dropped, mdrop);
      chk("a_drained", ifa.drained, mst == M_DONE);
      if (ifb.hostValid && ifb.hostReady) rxb.push_back(ifb.hostData);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain_a(input int budget);
    ifa.hostReady = 1'b1;
    ifa.outWrite  = 1'b0;
    for (int i = 0; i < budget && (ifa.count != 0 || ifa.hostValid); i++)
      tick();
    chk("a_drain_timeout", ifa.count, 0);
    ifa.hostReady = 1'b0;
  endtask

  int sent;

  initial begin
    ifa.outWrite = 0; ifa.outData = 0; ifa.finished = 0; ifa.hostReady = 0;
    ifb.outWrite = 0; ifb.outData = 0; ifb.finished = 0; ifb.hostReady = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", ifa.hostValid, 0);
    chk("rst_count", ifa.count, 0);
    chk("rst_outready", ifa.outReady, 1);
    chk("rst_overflow", ifa.overflow, 0);
    chk("rst_dropped", ifa.dropped, 0);
    chk("rst_drained", ifa.drained, 0);
    tick();
    reset = 1'b1;

    // Basic stream 10,20,30
    tick();
    ifa.hostReady = 1; ifa.outWrite = 1; ifa.outData = 12'd10;
    tick();
    ifa.outData = 12'd20;
    @(negedge clock);
    chk("basic_latency_valid", ifa.hostValid, 0);
    tick();
    ifa.outData = 12'd30;
    @(negedge clock);
    chk("basic_first_valid", ifa.hostValid, 1);
    chk("basic_first_data", ifa.hostData, 10);
    tick();
    ifa.outWrite = 0;
    drain_a(20);
    chk("basic_rx_size", rxa.size(), 3);
    for (int i = 0; i < rxa.size() && i < 3; i++)
      chk("basic_rx_word", rxa[i], 10 * (i + 1));
    chk("basic_overflow", ifa.overflow, 0);
    rxa.delete();

    // Full buffer with simultaneous read and write
    for (int v = 1; v <= N; v++) begin
      tick();
      ifa.outWrite = 1; ifa.outData = 12'(v);
    end
    tick();
    ifa.outWrite = 0;
    tick();
    ifa.outWrite = 1; ifa.outData = 12'd99; ifa.hostReady = 1;
    tick();
    ifa.outWrite = 0;
    @(negedge clock);
    chk("fullrw_count", ifa.count, 8);
    chk("fullrw_overflow", ifa.overflow, 0);
    drain_a(30);
    chk("fullrw_rx_size", rxa.size(), 9);
    for (int i = 0; i < rxa.size() && i < 9; i++)
      chk("fullrw_rx_word", rxa[i], (i < 8) ? i + 1 : 99);
    rxa.delete();

    // Fill and overflow
    for (int v = 1; v <= 10; v++) begin
      tick();
      ifa.outWrite = 1; ifa.outData = 12'(v);
    end
    tick();
    ifa.outWrite = 0;
    @(negedge clock);
    chk("ovf_count", ifa.count, 8);
    chk("ovf_outready", ifa.outReady, 0);
    chk("ovf_overflow", ifa.overflow, 1);
    chk("ovf_dropped", ifa.dropped, 2);
    chk("ovf_head", ifa.hostData, 1);
    drain_a(30);
    chk("ovf_rx_size", rxa.size(), 8);
    for (int i = 0; i < rxa.size() && i < 8; i++)
      chk("ovf_rx_word", rxa[i], i + 1);
    rxa.delete();

    // Finish and drain
    tick();
    ifa.outWrite = 1; ifa.outData = 12'd2; ifa.finished = 1;
    tick();
    ifa.outWrite = 0;
    repeat (5) tick();
    @(negedge clock);
    chk("fin_held_drained", ifa.drained, 0);
    chk("fin_held_data", ifa.hostData, 2);
    tick();
    ifa.hostReady = 1;
    tick();
    ifa.hostReady = 0;
    @(negedge clock);
    chk("fin_read_count", ifa.count, 0);
    tick();
    @(negedge clock);
    chk("fin_drained", ifa.drained, 1);
    tick();
    ifa.outWrite = 1; ifa.outData = 12'd7;
    tick();
    ifa.outWrite = 0;
    @(negedge clock);
    chk("late_push_drained", ifa.drained, 0);
    tick();
    tick();
    @(negedge clock);
    chk("late_held_drained", ifa.drained, 0);
    chk("late_held_data", ifa.hostData, 7);
    tick();
    ifa.hostReady = 1;
    tick();
    ifa.hostReady = 0;
    tick();
    @(negedge clock);
    chk("late_drained", ifa.drained, 1);
    tick();
    ifa.finished = 0;
    tick();
    @(negedge clock);
    chk("unfinish_drained", ifa.drained, 0);

    // Reset mid-stream
    for (int v = 1; v <= 4; v++) begin
      tick();
      ifa.outWrite = 1; ifa.outData = 12'(11 * v);
    end
    tick();
    ifa.outWrite = 0;
    @(negedge clock);
    chk("mid_count_before", ifa.count, 4);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", ifa.hostValid, 0);
    chk("mid_rst_count", ifa.count, 0);
    chk("mid_rst_overflow", ifa.overflow, 0);
    chk("mid_rst_dropped", ifa.dropped, 0);
    #1 reset = 1'b1;
    rxa.delete();
    tick();
    ifa.outWrite = 1; ifa.outData = 12'd5; ifa.hostReady = 1;
    tick();
    ifa.outWrite = 0;
    repeat (3) tick();
    ifa.hostReady = 0;
    chk("mid_rx_size", rxa.size(), 1);
    if (rxa.size() > 0) chk("mid_rx_first", rxa[0], 5);

    // Wrap-around on the NOut=3 instance
    sent = 0;
    for (int c = 0; c < 400 && (sent < 20 || rxb.size() < 20); c++) begin
      tick();
      ifb.hostReady = 1'($urandom_range(0, 1));
      if (sent < 20 && ifb.outReady) begin
        ifb.outWrite = 1;
        ifb.outData = 12'(100 + sent);
        sent++;
      end else begin
        ifb.outWrite = 0;
      end
    end
    ifb.outWrite = 0;
    tick();
    ifb.hostReady = 0;
    chk("wrap_rx_size", rxb.size(), 20);
    for (int i = 0; i < rxb.size() && i < 20; i++)
      chk("wrap_rx_word", rxb[i], 100 + i);
    chk("wrap_overflow", ifb.overflow, 0);
    chk("wrap_count", ifb.count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
